fir_sample_sequencer: RTL and testbench

- Controller for the filter's circular sample RAM: 18-bit synchronous RAM, one write port, one registered read port, 1-cycle read latency.
- Accepts one input sample per valid/ready handshake and writes it at the write pointer.
- Then issues NumTaps reads, newest to oldest, and emits tap-aligned valid, coefficient index and first/last markers for the MAC stage.
- Sits between the front-end sample stream and the samples RAM plus MAC.

---
 rtl/fir_sample_sequencer.sv | 138 +++++++++++++
 tb/tb_fir_sample_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sample_sequencer.sv
// Purpose: circular sample RAM controller for the FIR; writes one sample, then reads NumTaps taps newest-to-oldest.
// Latency: write in the handshake cycle, reads in cycles 1..NumTaps, tap markers in cycles 2..NumTaps+1.
// Backpressure: sample_ready_o is low while reading, zero-filling or clearing; samples are never captured while it is low.
// Optional build macro SAMPLES_SEQ_ZERO_FILL_EN: clear_i also zero-fills the whole RAM before returning to IDLE.
module fir_sample_sequencer #(
    parameter int unsigned DataWidth = 18,
    parameter int unsigned AddrWidth = 7,
    parameter int unsigned NumTaps   = 64
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 sample_valid_i,
    output logic                 sample_ready_o,
    input  logic [DataWidth-1:0] sample_i,
    output logic                 ram_wen_o,
    output logic [AddrWidth-1:0] ram_wr_addr_o,
    output logic [DataWidth-1:0] ram_wdata_o,
    output logic                 ram_ren_o,
    output logic [AddrWidth-1:0] ram_rd_addr_o,
    output logic                 tap_valid_o,
    output logic [AddrWidth-1:0] coef_idx_o,
    output logic                 first_tap_o,
    output logic                 last_tap_o,
    output logic                 busy_o
);

    // Tap count must fit the circular buffer.
    if (NumTaps < 1 || NumTaps > (1 << AddrWidth)) begin : g_bad_numtaps
        $error("fir_sample_sequencer: NumTaps must be in 1..2**AddrWidth");
    end

    localparam logic [AddrWidth-1:0] LastK = AddrWidth'(NumTaps - 1);

`ifdef SAMPLES_SEQ_ZERO_FILL_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1, S_ZERO = 2'd2} state_e;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_READ = 2'd1} state_e;
`endif

    state_e               state_q;
    logic [AddrWidth-1:0] wr_ptr_q;
    logic [AddrWidth-1:0] base_q;
    logic [AddrWidth-1:0] k_q;
    logic                 tap_valid_q;
    logic [AddrWidth-1:0] coef_idx_q;
    logic                 first_tap_q;
    logic                 last_tap_q;
    logic                 handshake;
`ifdef SAMPLES_SEQ_ZERO_FILL_EN
    logic [AddrWidth-1:0] fill_q;
    logic                 zero_wen;
`endif

    // Handshake and RAM port drive; clear_i and reset silence every RAM access in the same cycle.
    always_comb begin
        sample_ready_o = rst_ni & ~clear_i & (state_q == S_IDLE);
        handshake      = sample_valid_i & sample_ready_o;
        ram_ren_o      = ~clear_i & (state_q == S_READ);
        ram_rd_addr_o  = base_q - k_q;
        ram_wdata_o    = handshake ? sample_i : '0;
        busy_o         = (state_q != S_IDLE);
`ifdef SAMPLES_SEQ_ZERO_FILL_EN
        zero_wen       = ~clear_i & (state_q == S_ZERO);
        ram_wen_o      = handshake | zero_wen;
        ram_wr_addr_o  = zero_wen ? fill_q : wr_ptr_q;
`else
        ram_wen_o      = handshake;
        ram_wr_addr_o  = wr_ptr_q;
`endif
    end

    // Sequencer FSM plus the one-cycle tap marker pipeline aligned with RAM read data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            base_q      <= '0;
            k_q         <= '0;
            tap_valid_q <= 1'b0;
            coef_idx_q  <= '0;
            first_tap_q <= 1'b0;
            last_tap_q  <= 1'b0;
`ifdef SAMPLES_SEQ_ZERO_FILL_EN
            fill_q      <= '0;
`endif
        end else begin
            tap_valid_q <= ram_ren_o;
            coef_idx_q  <= ram_ren_o ? k_q : '0;
            first_tap_q <= ram_ren_o & (k_q == '0);
            last_tap_q  <= ram_ren_o & (k_q == LastK);
            if (clear_i) begin
                wr_ptr_q <= '0;
                k_q      <= '0;
`ifdef SAMPLES_SEQ_ZERO_FILL_EN
                fill_q   <= '0;
                state_q  <= S_ZERO;
`else
                state_q  <= S_IDLE;
`endif
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (handshake) begin
                            base_q   <= wr_ptr_q;
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                            k_q      <= '0;
                            state_q  <= S_READ;
                        end
                    end
                    S_READ: begin
                        if (k_q == LastK) begin
                            k_q     <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
`ifdef SAMPLES_SEQ_ZERO_FILL_EN
                    S_ZERO: begin
                        fill_q <= fill_q + 1'b1;
                        if (fill_q == '1) begin
                            state_q <= S_IDLE;
                        end
                    end
`endif
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign tap_valid_o = tap_valid_q;
    assign coef_idx_o  = coef_idx_q;
    assign first_tap_o = first_tap_q;
    assign last_tap_o  = last_tap_q;

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Purpose: randomized and directed bench for fir_sample_sequencer with a cycle-timeline reference model.
// Latency: model predicts writes at handshake, reads at +1..+NT, taps at +2..+NT+1.
// Backpressure: stimulus holds sample_valid_i until the sequencer accepts.
module tb_fir_sample_sequencer;
    localparam int DW    = 18;
    localparam int AW    = 3;
    localparam int NT    = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          clear_i;
    logic          sample_valid_i;
    logic          sample_ready_o;
    logic [DW-1:0] sample_i;
    logic          ram_wen_o;
    logic [AW-1:0] ram_wr_addr_o;
    logic [DW-1:0] ram_wdata_o;
    logic          ram_ren_o;
    logic [AW-1:0] ram_rd_addr_o;
    logic          tap_valid_o;
    logic [AW-1:0] coef_idx_o;
    logic          first_tap_o;
    logic          last_tap_o;
    logic          busy_o;

    fir_sample_sequencer #(.DataWidth(DW), .AddrWidth(AW), .NumTaps(NT)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clear_i        (clear_i),
        .sample_valid_i (sample_valid_i),
        .sample_ready_o (sample_ready_o),
        .sample_i       (sample_i),
        .ram_wen_o      (ram_wen_o),
        .ram_wr_addr_o  (ram_wr_addr_o),
        .ram_wdata_o    (ram_wdata_o),
        .ram_ren_o      (ram_ren_o),
        .ram_rd_addr_o  (ram_rd_addr_o),
        .tap_valid_o    (tap_valid_o),
        .coef_idx_o     (coef_idx_o),
        .first_tap_o    (first_tap_o),
        .last_tap_o     (last_tap_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural sample RAM: reset contents 0, registered read port.
    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] ram_q;
    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = '0;
        ram_q = '0;
    end
    always @(posedge clk_i) begin
        if (ram_wen_o) ram[ram_wr_addr_o] <= ram_wdata_o;
        if (ram_ren_o) ram_q <= ram[ram_rd_addr_o];
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: what the spec says happens this cycle, given the history of accepted samples.
    bit            have_op;
    int            t_hs, base, wptr, zl, d;
    bit            clr, rd, tv, zf, busy, rdy, hs, wz;
    logic [DW-1:0] img     [DEPTH];
    logic [DW-1:0] exp_dat [NT];

    initial begin
        have_op = 0; t_hs = 0; base = 0; wptr = 0; zl = 0;
        for (int i = 0; i < DEPTH; i++) img[i] = '0;
        for (int i = 0; i < NT; i++) exp_dat[i] = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                check_eq("rst_wen",   32'(ram_wen_o), 0);
                check_eq("rst_waddr", 32'(ram_wr_addr_o), 0);
                check_eq("rst_wdata", 32'(ram_wdata_o), 0);
                check_eq("rst_ren",   32'(ram_ren_o), 0);
                check_eq("rst_raddr", 32'(ram_rd_addr_o), 0);
                check_eq("rst_tapv",  32'(tap_valid_o), 0);
                check_eq("rst_coef",  32'(coef_idx_o), 0);
                check_eq("rst_first", 32'(first_tap_o), 0);
                check_eq("rst_last",  32'(last_tap_o), 0);
                check_eq("rst_busy",  32'(busy_o), 0);
                check_eq("rst_ready", 32'(sample_ready_o), 0);
                have_op = 0; wptr = 0; zl = 0;
            end else begin
                d    = have_op ? (cyc - t_hs) : 1000;
                clr  = clear_i;
                rd   = have_op && d >= 1 && d <= NT;
                tv   = have_op && d >= 2 && d <= NT + 1;
                zf   = (zl > 0);
                busy = rd || zf;
                rdy  = !clr && !busy;
                hs   = rdy && sample_valid_i;
                wz   = zf && !clr;
                check_eq("ready", 32'(sample_ready_o), 32'(rdy));
                check_eq("busy",  32'(busy_o), 32'(busy));
                check_eq("ren",   32'(ram_ren_o), 32'(rd && !clr));
                check_eq("wen",   32'(ram_wen_o), 32'(hs || wz));
                if (hs) begin
                    check_eq("waddr", 32'(ram_wr_addr_o), 32'(wptr));
                    check_eq("wdata", 32'(ram_wdata_o), 32'(sample_i));
                end
                if (wz) begin
                    check_eq("zaddr", 32'(ram_wr_addr_o), 32'(DEPTH - zl));
                    check_eq("zdata", 32'(ram_wdata_o), 0);
                end
                if (rd && !clr) check_eq("raddr", 32'(ram_rd_addr_o), 32'((base - (d - 1)) & (DEPTH - 1)));
                check_eq("tapv", 32'(tap_valid_o), 32'(tv));
                if (tv) begin
                    check_eq("coef",  32'(coef_idx_o), 32'(d - 2));
                    check_eq("first", 32'(first_tap_o), 32'(d == 2));
                    check_eq("last",  32'(last_tap_o), 32'(d == NT + 1));
                    check_eq("tapdat", 32'(ram_q), 32'(exp_dat[d - 2]));
                end
                if (clr) begin
                    have_op = 0; wptr = 0;
`ifdef SAMPLES_SEQ_ZERO_FILL_EN
                    zl = DEPTH;
`endif
                end else if (zf) begin
                    img[DEPTH - zl] = '0;
                    zl--;
                end else if (hs) begin
                    img[wptr] = sample_i;
                    base = wptr;
                    for (int k = 0; k < NT; k++) exp_dat[k] = img[(base - k) & (DEPTH - 1)];
                    t_hs = cyc;
                    have_op = 1;
                    wptr = (wptr + 1) % DEPTH;
                end
            end
            cyc++;
        end
    end

    task automatic push(input logic [DW-1:0] v);
        int n;
        n = 0;
        sample_i = v;
        sample_valid_i = 1'b1;
        forever begin
            @(negedge clk_i);
            if (sample_ready_o) break;
            n++;
            if (n > 100) begin
                check_eq("push_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk_i);
        #1 sample_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        @(posedge clk_i);
        #1 clear_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b1; clear_i = 1'b0; sample_valid_i = 1'b0; sample_i = '0;
        #2 rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        idle(1);

        // Single push of 5 from reset.
        push(18'd5);
        idle(6);

        // Nine samples 1..9 from a freshly cleared pointer: the ninth wraps to address 0.
        pulse_clear();
        idle(10);
        for (int i = 1; i <= 9; i++) push(DW'(i));
        idle(6);

        // Valid held high continuously with random data.
        sample_valid_i = 1'b1;
        repeat (60) begin
            sample_i = DW'($urandom);
            @(posedge clk_i);
            #1;
        end
        sample_valid_i = 1'b0;
        idle(6);

        // Clear during the read with k=2, then the next sample must land at address 0.
        push(DW'($urandom));
        idle(2);
        pulse_clear();
        push(DW'($urandom));
        idle(6);

        // Reset asserted mid-read.
        push(DW'($urandom));
        rst_ni = 1'b0;
        #1;
        check_eq("rst_imm_ren", 32'(ram_ren_o), 0);
        check_eq("rst_imm_busy", 32'(busy_o), 0);
        idle(2);
        rst_ni = 1'b1;
        push(DW'($urandom));
        idle(6);

        // Random valid / rare clear traffic.
        repeat (400) begin
            sample_valid_i = 1'($urandom_range(0, 1));
            clear_i        = ($urandom_range(0, 19) == 0);
            sample_i       = DW'($urandom);
            @(posedge clk_i);
            #1;
        end
        sample_valid_i = 1'b0;
        clear_i = 1'b0;
        idle(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
